// File: rtl/numeric_display_pkg.sv
// Shared types and constants for the KW4-56NCWB-P-Y numeric display driver.
//   - Pin bit positions of the 14-pin display bus
//   - Scan state enumeration
//   - display_set_t: one complete display image {value, dp, blank, colon}
//   - lz_mask(): leading-zero mask helper (used when NUMERIC_DISPLAY_LZS_EN is defined)
package numeric_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PIN_W      = 14;

  // Pin bit positions on the display bus
  localparam int unsigned SEG_LSB = 0;
  localparam int unsigned DP_BIT  = 7;
  localparam int unsigned SEL_LSB = 8;
  localparam int unsigned COLON_A = 12;
  localparam int unsigned COLON_K = 13;

  // All digit selects and colon common off, every anode low
  localparam logic [PIN_W-1:0] PINS_IDLE = 14'b10_1111_0000_0000;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] blank;
    logic                  colon;
  } display_set_t;

  // Image shown after reset: every digit blanked
  localparam display_set_t SET_RESET = '{
    value: 16'h0000,
    dp:    4'h0,
    blank: 4'hF,
    colon: 1'b0
  };

  // Bit i set when digit i is zero and every digit to its left is zero; digit 0 never set
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VALUE_W-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] & (v[11:8] == 4'h0);
    m[1] = m[2] & (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/numeric_display_driver_if.sv
// Load port of the numeric display driver: valid/ready handshake plus display image.
//   master (producer): drives LOAD_VALID, VALUE, DP, BLANK, COLON; samples LOAD_READY
//   slave  (driver)  : samples the load fields; drives LOAD_READY
interface numeric_display_driver_if;
  import numeric_display_pkg::*;

  logic                  LOAD_VALID;
  logic                  LOAD_READY;
  logic [VALUE_W-1:0]    VALUE;
  logic [NUM_DIGITS-1:0] DP;
  logic [NUM_DIGITS-1:0] BLANK;
  logic                  COLON;

  modport master (
    output LOAD_VALID,
    output VALUE,
    output DP,
    output BLANK,
    output COLON,
    input  LOAD_READY
  );

  modport slave (
    input  LOAD_VALID,
    input  VALUE,
    input  DP,
    input  BLANK,
    input  COLON,
    output LOAD_READY
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment pattern (bit 0 = segment a, bit 6 = segment g).
//   digit_i : 4-bit hex digit
//   seg_c_o : active-high segment pattern, combinational
module seg7_hex_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_c_o
);

  // Standard hex glyphs with lowercase b and d so they differ from 8 and 0
  always_comb begin
    seg_c_o = 7'h00;
    unique case (digit_i)
      4'h0: seg_c_o = 7'h3F;
      4'h1: seg_c_o = 7'h06;
      4'h2: seg_c_o = 7'h5B;
      4'h3: seg_c_o = 7'h4F;
      4'h4: seg_c_o = 7'h66;
      4'h5: seg_c_o = 7'h6D;
      4'h6: seg_c_o = 7'h7D;
      4'h7: seg_c_o = 7'h07;
      4'h8: seg_c_o = 7'h7F;
      4'h9: seg_c_o = 7'h6F;
      4'hA: seg_c_o = 7'h77;
      4'hB: seg_c_o = 7'h7C;
      4'hC: seg_c_o = 7'h39;
      4'hD: seg_c_o = 7'h5E;
      4'hE: seg_c_o = 7'h79;
      4'hF: seg_c_o = 7'h71;
      default: seg_c_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/numeric_display_driver.sv
// Multiplexed scan driver for the KW4-56NCWB-P-Y 4-digit 7-segment display.
// A display image is loaded through a valid/ready port into a pending register and
// copied to the displayed (shadow) image only on the frame boundary (last DRIVE cycle
// of digit 3), so a frame never mixes two images. Each digit slot is a short BLANK
// phase with all selects off (anti-ghosting) followed by a DRIVE phase.
//
// Parameters:
//   C_SCAN_DIV     : cycles per digit slot (BLANK + DRIVE)
//   C_BLANK_CYCLES : BLANK cycles per slot, 1 <= C_BLANK_CYCLES < C_SCAN_DIV
// Ports:
//   MCLK                : clock
//   nRST                : asynchronous active-low reset
//   load_if             : load port (slave modport), LOAD_READY registered
//   KW4_56NCWB_P_Y_pins : registered display pins
//                         [6:0] seg a..g, [7] dp, [11:8] digit selects (active low),
//                         [12] colon anode, [13] colon common (active low)
// Build option:
//   NUMERIC_DISPLAY_LZS_EN : leading-zero suppression on digits 3..1
module numeric_display_driver
  import numeric_display_pkg::*;
#(
  parameter int unsigned C_SCAN_DIV     = 2500,
  parameter int unsigned C_BLANK_CYCLES = 8
) (
  input  logic                     MCLK,
  input  logic                     nRST,
  numeric_display_driver_if.slave  load_if,
  output logic [PIN_W-1:0]         KW4_56NCWB_P_Y_pins
);

  localparam int unsigned CNT_W = $clog2(C_SCAN_DIV);
  localparam int unsigned DIG_W = 2;

  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(C_BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(C_SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST       = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DIG_W-1:0] DIG_COLON      = DIG_W'(1);

  localparam logic [0:0] S_BLANK = ST_BLANK;
  localparam logic [0:0] S_DRIVE = ST_DRIVE;

  logic [0:0]       state_q,   state_d;
  logic [DIG_W-1:0] digit_q,   digit_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  display_set_t     shadow_q,  shadow_d;
  display_set_t     pending_q, pending_d;
  logic             ready_q,   ready_d;
  logic [PIN_W-1:0] pins_q,    pins_d;

  logic                  boundary_c;
  logic                  xfer_c;
  display_set_t          load_set_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic [SEG_W-1:0]      glyph_c;
  logic [NUM_DIGITS-1:0] lz_c;
  logic                  seg_dark_c;
  logic                  dp_dark_c;

  assign load_if.LOAD_READY  = ready_q;
  assign KW4_56NCWB_P_Y_pins = pins_q;

  assign boundary_c = (state_q == S_DRIVE) && (digit_q == DIG_LAST) && (cnt_q == CNT_SLOT_LAST);
  assign xfer_c     = load_if.LOAD_VALID & ready_q;

  assign load_set_c = '{
    value: load_if.VALUE,
    dp:    load_if.DP,
    blank: load_if.BLANK,
    colon: load_if.COLON
  };

`ifdef NUMERIC_DISPLAY_LZS_EN
  assign lz_c = lz_mask(shadow_q.value);
`else
  assign lz_c = '0;
`endif

  // Single decoder on the digit currently selected by the scan
  assign nibble_c = shadow_q.value[{digit_q, 2'b00} +: NIBBLE_W];

  seg7_hex_decoder u_dec (
    .digit_i (nibble_c),
    .seg_c_o (glyph_c)
  );

  // Suppressed leading zeros lose their segments but keep their DP
  assign seg_dark_c = shadow_q.blank[digit_q] | lz_c[digit_q];
  assign dp_dark_c  = shadow_q.blank[digit_q];

  // State register
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_BLANK;
      digit_q   <= '0;
      cnt_q     <= '0;
      shadow_q  <= SET_RESET;
      pending_q <= SET_RESET;
      ready_q   <= 1'b1;
      pins_q    <= PINS_IDLE;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      pins_q    <= pins_d;
    end
  end

  // Scan sequencing: the slot counter runs 0..C_SCAN_DIV-1 across BLANK and DRIVE
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == CNT_BLANK_LAST) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_SLOT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = digit_q + DIG_W'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
        digit_d = '0;
      end
    endcase
  end

  // Load path: pending image is promoted on the boundary; an empty pending lets a
  // coincident load go straight to the shadow without ever looking busy
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    if (boundary_c) begin
      if (!ready_q) begin
        shadow_d = pending_q;
        ready_d  = 1'b1;
      end else if (xfer_c) begin
        shadow_d = load_set_c;
      end
    end else if (xfer_c) begin
      pending_d = load_set_c;
      ready_d   = 1'b0;
    end
  end

  // Pin image for the current scan position, registered one cycle later
  always_comb begin
    pins_d = PINS_IDLE;
    if (state_q == S_DRIVE) begin
      pins_d[SEL_LSB +: NUM_DIGITS] = ~(NUM_DIGITS'(1) << digit_q);
      pins_d[SEG_LSB +: SEG_W]      = seg_dark_c ? '0 : glyph_c;
      pins_d[DP_BIT]                = dp_dark_c ? 1'b0 : shadow_q.dp[digit_q];
      if (digit_q == DIG_COLON) begin
        pins_d[COLON_A] = shadow_q.colon;
        pins_d[COLON_K] = ~shadow_q.colon;
      end
    end
  end

endmodule

// File: tb/tb_numeric_display_driver.sv
`timescale 1ns/1ps
module tb_numeric_display_driver;

  localparam int SCAN  = 16;
  localparam int BLNK  = 2;
  localparam int FRAME = 4 * SCAN;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        colon;
  } dset_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] pins;

  numeric_display_driver_if u_if ();

  numeric_display_driver #(
    .C_SCAN_DIV     (SCAN),
    .C_BLANK_CYCLES (BLNK)
  ) dut (
    .MCLK                (clk),
    .nRST                (rst_n),
    .load_if             (u_if),
    .KW4_56NCWB_P_Y_pins (pins)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame position, displayed image, pending image
  dset_t       sh, pd;
  logic        pd_full;
  int          pos;
  int          pins_pos;
  logic [13:0] exp_pins;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // Pins the display should show for frame position p with image s
  function automatic logic [13:0] model_pins(input int p, input dset_t s);
    logic [13:0] r;
    int d, off;
    logic seg_dark;
    d   = p / SCAN;
    off = p % SCAN;
    r   = 14'h2F00;
    if (off >= BLNK) begin
      r[8 + d] = 1'b0;
      seg_dark = s.bl[d];
`ifdef NUMERIC_DISPLAY_LZS_EN
      if (d > 0 && (s.v >> (4 * d)) == 16'h0) seg_dark = 1'b1;
`endif
      if (!seg_dark) r[6:0] = hex7(s.v[4 * d +: 4]);
      if (!s.bl[d]) r[7] = s.dp[d];
      if (d == 1) begin
        r[12] = s.colon;
        r[13] = ~s.colon;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    sh       = {16'h0000, 4'h0, 4'hF, 1'b0};
    pd       = '0;
    pd_full  = 1'b0;
    pos      = 0;
    pins_pos = -1;
    exp_pins = 14'h2F00;
  endtask

  // One clock: advance the model with the current inputs, then step the DUT
  task automatic tick();
    dset_t in_s;
    logic  acc;
    in_s     = {u_if.VALUE, u_if.DP, u_if.BLANK, u_if.COLON};
    exp_pins = model_pins(pos, sh);
    pins_pos = pos;
    acc      = u_if.LOAD_VALID && !pd_full;
    if (pos == FRAME - 1) begin
      if (pd_full) begin
        sh      = pd;
        pd_full = 1'b0;
      end else if (acc) begin
        sh = in_s;
      end
    end else if (acc) begin
      pd      = in_s;
      pd_full = 1'b1;
    end
    pos = (pos + 1) % FRAME;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < FRAME && pos != p; i++) tick();
  endtask

  task automatic drive_idle();
    u_if.LOAD_VALID = 1'b0;
    u_if.VALUE      = 16'($urandom);
    u_if.DP         = 4'($urandom);
    u_if.BLANK      = 4'($urandom);
    u_if.COLON      = 1'($urandom);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic c);
    u_if.LOAD_VALID = 1'b1;
    u_if.VALUE      = v;
    u_if.DP         = dp;
    u_if.BLANK      = bl;
    u_if.COLON      = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (pins !== 14'h2F00) begin
      failures++;
      $display("FAIL reset_pins got=%h exp=%h", pins, 14'h2F00);
    end
    checks++;
    if (u_if.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", u_if.LOAD_READY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (pins !== 14'h2F00) begin
      failures++;
      $display("FAIL release_blank got=%h exp=%h", pins, 14'h2F00);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] walk [4];
    walk = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive_idle();
      tick();
      checks++;
      if (pins !== exp_pins) begin
        failures++;
        $display("FAIL idle_pins pos=%0d got=%h exp=%h", pins_pos, pins, exp_pins);
      end
      if (pins_pos % SCAN == 0) begin
        checks++;
        if (pins !== 14'h2F00) begin
          failures++;
          $display("FAIL idle_blank pos=%0d got=%h exp=2f00", pins_pos, pins);
        end
      end
      if (pins_pos % SCAN == 5) begin
        checks++;
        if (pins[11:0] !== {walk[pins_pos / SCAN], 8'h00}) begin
          failures++;
          $display("FAIL idle_walk pos=%0d got=%h exp=%h", pins_pos, pins[11:0],
                   {walk[pins_pos / SCAN], 8'h00});
        end
      end
    end
  endtask

  task automatic test_load_digits();
    logic [7:0] exp_lo [4];
    exp_lo = '{8'h71, 8'h77, 8'hDB, 8'h06};
    run_to_pos(20);
    drive_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
    tick();
    drive_idle();
    checks++;
    if (u_if.LOAD_READY !== 1'b0) begin
      failures++;
      $display("FAIL load_busy got=%b exp=0", u_if.LOAD_READY);
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if (pins !== exp_pins || u_if.LOAD_READY !== !pd_full) begin
        failures++;
        $display("FAIL load_pins pos=%0d got=%h/%b exp=%h/%b", pins_pos, pins,
                 u_if.LOAD_READY, exp_pins, !pd_full);
      end
      if (i >= 2 * FRAME && pins_pos % SCAN == 7) begin
        checks++;
        if (pins[7:0] !== exp_lo[pins_pos / SCAN]) begin
          failures++;
          $display("FAIL load_digit%0d got=%h exp=%h", pins_pos / SCAN, pins[7:0],
                   exp_lo[pins_pos / SCAN]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic        got;
    int          seen;
    a = 16'($urandom);
    b = 16'($urandom);
    b[3:0] = a[3:0] ^ 4'h5;
    run_to_pos(10);
    drive_load(a, 4'($urandom), 4'h0, 1'b0);
    tick();
    checks++;
    if (u_if.LOAD_READY !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy got=%b exp=0", u_if.LOAD_READY);
    end
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (u_if.LOAD_READY === 1'b1) begin
        got = 1'b1;
        break;
      end
      drive_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      checks++;
      if (pins !== exp_pins) begin
        failures++;
        $display("FAIL b2b_wait_pins pos=%0d got=%h exp=%h", pins_pos, pins, exp_pins);
      end
    end
    checks++;
    if (!got || pos != 0) begin
      failures++;
      $display("FAIL b2b_ready_rise got=%b at_pos=%0d exp=1 at_pos=0", got, pos);
    end
    drive_load(b, 4'($urandom), 4'h0, 1'b0);
    tick();
    drive_idle();
    seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (pins !== exp_pins || u_if.LOAD_READY !== !pd_full) begin
        failures++;
        $display("FAIL b2b_pins pos=%0d got=%h/%b exp=%h/%b", pins_pos, pins,
                 u_if.LOAD_READY, exp_pins, !pd_full);
      end
      if (pins_pos == 5) begin
        checks++;
        if (pins[6:0] !== hex7(seen == 0 ? a[3:0] : b[3:0])) begin
          failures++;
          $display("FAIL b2b_frame%0d got=%h exp=%h", seen, pins[6:0],
                   hex7(seen == 0 ? a[3:0] : b[3:0]));
        end
        seen++;
      end
    end
  endtask

  task automatic test_boundary_bypass();
    logic [15:0] c;
    int          lat;
    c = 16'($urandom);
    run_to_pos(FRAME - 1);
    drive_load(c, 4'h0, 4'h0, 1'b0);
    tick();
    drive_idle();
    checks++;
    if (u_if.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL bypass_ready got=%b exp=1", u_if.LOAD_READY);
    end
    lat = -1;
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      checks++;
      if (pins !== exp_pins) begin
        failures++;
        $display("FAIL bypass_pins pos=%0d got=%h exp=%h", pins_pos, pins, exp_pins);
      end
      if (pins[11:8] === 4'hE) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != BLNK + 1) begin
      failures++;
      $display("FAIL bypass_latency got=%0d exp=%0d", lat, BLNK + 1);
    end
    checks++;
    if (pins[6:0] !== hex7(c[3:0])) begin
      failures++;
      $display("FAIL bypass_digit0 got=%h exp=%h", pins[6:0], hex7(c[3:0]));
    end
  endtask

  task automatic test_colon();
    int   cnt;
    logic in_d1;
    run_to_pos(30);
    drive_load(16'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    tick();
    drive_idle();
    run_to_pos(0);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      in_d1 = (pins_pos >= SCAN + BLNK) && (pins_pos < 2 * SCAN);
      if (pins[13:12] === 2'b01) cnt++;
      checks++;
      if (pins[13:12] !== (in_d1 ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL colon_bits pos=%0d got=%b exp=%b", pins_pos, pins[13:12],
                 in_d1 ? 2'b01 : 2'b10);
      end
    end
    checks++;
    if (cnt != SCAN - BLNK) begin
      failures++;
      $display("FAIL colon_count got=%0d exp=%0d", cnt, SCAN - BLNK);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0)
        drive_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      else
        drive_idle();
      tick();
      checks++;
      if (pins !== exp_pins || u_if.LOAD_READY !== !pd_full) begin
        failures++;
        $display("FAIL rand_pins pos=%0d got=%h/%b exp=%h/%b", pins_pos, pins,
                 u_if.LOAD_READY, exp_pins, !pd_full);
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    run_to_pos(36);
    drive_load(16'($urandom), 4'($urandom), 4'h0, 1'b1);
    tick();
    drive_idle();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pins !== 14'h2F00 || u_if.LOAD_READY !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%h/%b exp=2f00/1", pins, u_if.LOAD_READY);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (pins !== exp_pins || u_if.LOAD_READY !== !pd_full) begin
        failures++;
        $display("FAIL post_reset pos=%0d got=%h/%b exp=%h/%b", pins_pos, pins,
                 u_if.LOAD_READY, exp_pins, !pd_full);
      end
    end
  endtask

`ifdef NUMERIC_DISPLAY_LZS_EN
  task automatic test_lzs();
    logic [15:0] vals [2];
    logic [6:0]  d0 [2];
    vals = '{16'h0005, 16'h0000};
    d0   = '{7'h6D, 7'h3F};
    for (int k = 0; k < 2; k++) begin
      run_to_pos(20);
      drive_load(vals[k], 4'h0, 4'h0, 1'b0);
      tick();
      drive_idle();
      run_to_pos(0);
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (pins_pos % SCAN == 7) begin
          checks++;
          if (pins[6:0] !== (pins_pos < SCAN ? d0[k] : 7'h00)) begin
            failures++;
            $display("FAIL lzs_%0d_digit%0d got=%h exp=%h", k, pins_pos / SCAN,
                     pins[6:0], pins_pos < SCAN ? d0[k] : 7'h00);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_load_digits();
    test_back_to_back();
    test_boundary_bypass();
    test_colon();
    test_random();
    test_async_reset();
`ifdef NUMERIC_DISPLAY_LZS_EN
    test_lzs();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
